// File: rtl/jpeg_enc_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the JPEG
// quantise/zigzag datapath.
package jpeg_enc_pkg;

    localparam int unsigned DCT_W    = 18;   // signed DCT coefficient
    localparam int unsigned COEF_W   = 15;   // quantised zigzag coefficient
    localparam int unsigned FDTBL_W  = 8;    // unsigned quantiser reciprocal
    localparam int unsigned BLK_SIZE = 64;   // coefficients per 8x8 block
    localparam int unsigned IDX_W    = 6;    // block index width
    localparam int unsigned PROD_W   = DCT_W + FDTBL_W + 1;

    localparam int SAT_MAX = 16383;
    localparam int SAT_MIN = -16384;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jpeg_quant_mul.sv
// Quantiser back end: registered multiply, then round-half-up, arithmetic
// shift and 15-bit reduction (saturate when JPEG_QUANT_SAT_EN is defined,
// otherwise two's-complement wrap).
// Ports:
//   clk, reset_n            clock, async active-low reset
//   in_valid, in_idx        stage-2 valid and zigzag index
//   dct, fdtbl              coefficient and reciprocal (valid with in_valid)
//   out_valid, out_idx      write strobe and address
//   out_data                reduced coefficient
module jpeg_quant_mul
    import jpeg_enc_pkg::*;
#(
    parameter int unsigned SHIFT = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [DCT_W-1:0]  dct,
    input  logic [FDTBL_W-1:0]       fdtbl,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    output logic [COEF_W-1:0]        out_data
);

    localparam int unsigned RND_W = PROD_W + 1;
    localparam int          HALF  = 1 << (SHIFT - 1);

    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  shifted;

    // Reciprocal is unsigned: zero-extend before the signed multiply.
    assign prod_d = PROD_W'(dct) * PROD_W'($signed({1'b0, fdtbl}));

    // Stage 2 register; index and product hold their last value when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q    <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod_q  <= prod_d;
                out_idx <= in_idx;
            end
        end
    end

    assign rnd     = RND_W'(prod_q) + RND_W'(HALF);
    assign shifted = rnd >>> SHIFT;

`ifdef JPEG_QUANT_SAT_EN
    // Clamp to the 15-bit signed range.
    always_comb begin
        out_data = COEF_W'(shifted);
        if (shifted > RND_W'(SAT_MAX)) begin
            out_data = COEF_W'(SAT_MAX);
        end else if (shifted < RND_W'(SAT_MIN)) begin
            out_data = COEF_W'(SAT_MIN);
        end
    end
`else
    // Wrap: keep the low bits, upper bits intentionally dropped.
    logic unused_hi_bits;
    assign unused_hi_bits = ^shifted[RND_W-1:COEF_W];

    always_comb begin
        out_data = shifted[COEF_W-1:0];
    end
`endif

endmodule

// File: rtl/jpeg_quant_zz.sv
// Quantise one 8x8 DCT block and write it in zigzag order.
// Optional feature: define JPEG_QUANT_SAT_EN for saturating 15-bit output
// (default build wraps).
// Ports:
//   clk, reset_n                clock, async active-low reset
//   start, comp                 block request and table select (0=Y, 1=UV)
//   busy, done                  status / completion pulse
//   zzidx_rom_a/_d              zigzag index ROM (registered data)
//   dctdu_ram_ar/_do            DCT coefficient RAM read port
//   fdtbl_rom_a/_d              reciprocal ROM ({comp, index})
//   zzdu_ram_aw/_di/_we         zigzag coefficient RAM write port
module jpeg_quant_zz
    import jpeg_enc_pkg::*;
#(
    parameter int unsigned SHIFT = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     comp,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         zzidx_rom_a,
    input  logic [IDX_W-1:0]         zzidx_rom_d,
    output logic [IDX_W-1:0]         dctdu_ram_ar,
    input  logic signed [DCT_W-1:0]  dctdu_ram_do,
    output logic [IDX_W:0]           fdtbl_rom_a,
    input  logic [FDTBL_W-1:0]       fdtbl_rom_d,
    output logic [IDX_W-1:0]         zzdu_ram_aw,
    output logic [COEF_W-1:0]        zzdu_ram_di,
    output logic                     zzdu_ram_we
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(BLK_SIZE - 1);

    state_t           state_q, state_d;
    logic             comp_q;
    logic [IDX_W-1:0] k_q;
    logic             busy_q, done_q;
    logic             s1_valid_q, s2_valid_q;
    logic [IDX_W-1:0] s1_k_q, s2_k_q;
    logic [IDX_W-1:0] ar_hold_q;
    logic [IDX_W:0]   fa_hold_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: FLUSH waits for the last write to leave the pipeline.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (k_q == LAST_K) state_d = FLUSH;
            FLUSH:   if (zzdu_ram_we && (zzdu_ram_aw == LAST_K)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags, table select and zigzag ROM address sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            comp_q <= 1'b0;
            k_q    <= '0;
        end else begin
            busy_q <= (state_d == RUN) || (state_d == FLUSH);
            done_q <= (state_d == DONE);
            if ((state_q == IDLE) && start) begin
                comp_q <= comp;
                k_q    <= '0;
            end else if ((state_q == RUN) && (k_q != LAST_K)) begin
                k_q <= k_q + IDX_W'(1);
            end
        end
    end

    // Valid/index pipeline tracking the external ROM/RAM latencies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_k_q     <= '0;
            s2_k_q     <= '0;
            ar_hold_q  <= '0;
            fa_hold_q  <= '0;
        end else begin
            s1_valid_q <= (state_q == RUN);
            s2_valid_q <= s1_valid_q;
            s1_k_q     <= k_q;
            s2_k_q     <= s1_k_q;
            if (s1_valid_q) begin
                ar_hold_q <= zzidx_rom_d;
                fa_hold_q <= {comp_q, zzidx_rom_d};
            end
        end
    end

    // Stage 1 forwards the ROM data straight to the read addresses so the
    // write lands 3 cycles after its index address; the hold registers keep
    // the addresses stable (and zero after reset) outside a block.
    assign dctdu_ram_ar = s1_valid_q ? zzidx_rom_d : ar_hold_q;
    assign fdtbl_rom_a  = s1_valid_q ? {comp_q, zzidx_rom_d} : fa_hold_q;

    assign zzidx_rom_a = k_q;
    assign busy        = busy_q;
    assign done        = done_q;

    jpeg_quant_mul #(
        .SHIFT (SHIFT)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s2_valid_q),
        .in_idx    (s2_k_q),
        .dct       (dctdu_ram_do),
        .fdtbl     (fdtbl_rom_d),
        .out_valid (zzdu_ram_we),
        .out_idx   (zzdu_ram_aw),
        .out_data  (zzdu_ram_di)
    );

endmodule

// File: tb/tb_jpeg_quant_zz.sv
// Self-checking bench for jpeg_quant_zz: models the index/coefficient/
// reciprocal memories, captures the zigzag RAM and compares against
// table vectors and an arithmetic reference.
module tb_jpeg_quant_zz;

    localparam int SHIFT = 10;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               comp;
    logic               busy;
    logic               done;
    logic [5:0]         zzidx_rom_a;
    logic [5:0]         zzidx_rom_d;
    logic [5:0]         dctdu_ram_ar;
    logic signed [17:0] dctdu_ram_do;
    logic [6:0]         fdtbl_rom_a;
    logic [7:0]         fdtbl_rom_d;
    logic [5:0]         zzdu_ram_aw;
    logic [14:0]        zzdu_ram_di;
    logic               zzdu_ram_we;

    always #5 clk = ~clk;

    jpeg_quant_zz #(.SHIFT(SHIFT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .comp         (comp),
        .busy         (busy),
        .done         (done),
        .zzidx_rom_a  (zzidx_rom_a),
        .zzidx_rom_d  (zzidx_rom_d),
        .dctdu_ram_ar (dctdu_ram_ar),
        .dctdu_ram_do (dctdu_ram_do),
        .fdtbl_rom_a  (fdtbl_rom_a),
        .fdtbl_rom_d  (fdtbl_rom_d),
        .zzdu_ram_aw  (zzdu_ram_aw),
        .zzdu_ram_di  (zzdu_ram_di),
        .zzdu_ram_we  (zzdu_ram_we)
    );

    // Memories around the block.
    logic [5:0]         zz_mem   [64];
    logic signed [17:0] dct_mem  [64];
    logic [7:0]         fd_mem   [128];
    logic [14:0]        zzdu_mem [64];
    int                 wr_cnt   = 0;
    int                 done_cnt = 0;

    int zz_std [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    always @(posedge clk) begin
        zzidx_rom_d  <= zz_mem[zzidx_rom_a];
        dctdu_ram_do <= dct_mem[dctdu_ram_ar];
        fdtbl_rom_d  <= fd_mem[fdtbl_rom_a];
    end

    always @(negedge clk) begin
        if (zzdu_ram_we === 1'b1) begin
            zzdu_mem[zzdu_ram_aw] <= zzdu_ram_di;
            wr_cnt <= wr_cnt + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: round-half-up, arithmetic shift, 15-bit reduction.
    function automatic logic [14:0] ref_q(input longint d, input longint f);
        longint r;
        r = (d * f + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef JPEG_QUANT_SAT_EN
        if (r > 16383) r = 16383;
        else if (r < -16384) r = -16384;
`endif
        return 15'(r);
    endfunction

    function automatic int model_errs(input logic c);
        int errs = 0;
        for (int k = 0; k < 64; k++) begin
            logic [5:0] i;
            i = zz_mem[k];
            if (zzdu_mem[k] !== ref_q(longint'(dct_mem[i]), longint'(fd_mem[{c, i}])))
                errs++;
        end
        return errs;
    endfunction

    function automatic int const_errs(input logic [14:0] v);
        int errs = 0;
        for (int k = 0; k < 64; k++) if (zzdu_mem[k] !== v) errs++;
        return errs;
    endfunction

    // Run one block; start accepted at edge t, cycle n is the one after t+n.
    task automatic run_block(input string name, input logic c, input bit poke);
        int  wr0, dn0;
        bit  tim_ok;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        tim_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        comp  = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        comp  = ~c;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (busy !== (n <= 67)) tim_ok = 1'b0;
            if (done !== (n == 68)) tim_ok = 1'b0;
            if (zzdu_ram_we !== (n >= 4 && n <= 67)) tim_ok = 1'b0;
            if (zzdu_ram_we === 1'b1 && zzdu_ram_aw !== 6'(n - 4)) tim_ok = 1'b0;
            start = poke && (n == 10 || n == 40 || n == 68);
        end
        start = 1'b0;
        @(negedge clk);
        check({name, "_timing"}, longint'(tim_ok), 1);
        check({name, "_writes"}, wr_cnt - wr0, 64);
        check({name, "_done"}, done_cnt - dn0, 1);
    endtask

    typedef struct {
        int          dct;
        int          fd;
        logic [14:0] exp_sat;
        logic [14:0] exp_wrap;
    } vec_t;

    vec_t vecs [12];

    task automatic fill_uniform(input int d, input int f);
        for (int i = 0; i < 64; i++) begin
            zz_mem[i]  = 6'(zz_std[i]);
            dct_mem[i] = 18'(d);
        end
        for (int i = 0; i < 128; i++) fd_mem[i] = 8'(f);
    endtask

    initial begin
        logic [14:0] e;
        int          nw, wr0, dn0;
        bit          got20;

        vecs[0]  = '{1024,    2, 15'h0002, 15'h0002};
        vecs[1]  = '{3,     200, 15'h0001, 15'h0001};
        vecs[2]  = '{-1,    200, 15'h0000, 15'h0000};
        vecs[3]  = '{-3,    200, 15'h7FFF, 15'h7FFF};
        vecs[4]  = '{131071, 255, 15'h3FFF, 15'h7F80};
        vecs[5]  = '{-131072, 255, 15'h4000, 15'h0080};
        vecs[6]  = '{512,     1, 15'h0001, 15'h0001};
        vecs[7]  = '{511,     1, 15'h0000, 15'h0000};
        vecs[8]  = '{-513,    1, 15'h7FFF, 15'h7FFF};
        vecs[9]  = '{131064, 128, 15'h3FFF, 15'h3FFF};
        vecs[10] = '{131071, 128, 15'h3FFF, 15'h4000};
        vecs[11] = '{-131072, 129, 15'h4000, 15'h3F80};

        reset_n = 1'b0;
        start   = 1'b0;
        comp    = 1'b0;
        fill_uniform(0, 0);
        #12;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_we", longint'(zzdu_ram_we), 0);
        check("rst_addrs", longint'({zzidx_rom_a, dctdu_ram_ar, fdtbl_rom_a, zzdu_ram_aw}), 0);
        check("rst_di", longint'(zzdu_ram_di), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors: uniform block, both table halves equal.
        for (int v = 0; v < 12; v++) begin
            fill_uniform(vecs[v].dct, vecs[v].fd);
`ifdef JPEG_QUANT_SAT_EN
            e = vecs[v].exp_sat;
`else
            e = vecs[v].exp_wrap;
`endif
            run_block($sformatf("vec%0d", v), 1'(v % 2), 1'b0);
            check($sformatf("vec%0d_data", v), const_errs(e), 0);
        end

        // Zigzag ordering.
        fill_uniform(0, 128);
        for (int i = 0; i < 64; i++) dct_mem[i] = 18'(8 * i);
        run_block("zigzag", 1'b0, 1'b0);
        check("zz2", longint'(zzdu_mem[2]), 8);
        check("zz3", longint'(zzdu_mem[3]), 16);
        check("zigzag_model", model_errs(1'b0), 0);

        // Table select with start pokes during busy and in the done cycle.
        fill_uniform(1024, 2);
        for (int i = 64; i < 128; i++) fd_mem[i] = 8'd4;
        run_block("chroma", 1'b1, 1'b1);
        check("chroma_data", const_errs(15'd4), 0);
        run_block("luma", 1'b0, 1'b1);
        check("luma_data", const_errs(15'd2), 0);

        // Abort after 20 writes.
        fill_uniform(1024, 2);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        nw = 0;
        got20 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        comp  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 100 && !got20; n++) begin
            @(negedge clk);
            if (zzdu_ram_we === 1'b1) nw++;
            if (nw == 20) got20 = 1'b1;
        end
        check("abort_reach20", longint'(got20), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_we", longint'(zzdu_ram_we), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_addrs", longint'({zzidx_rom_a, dctdu_ram_ar, fdtbl_rom_a, zzdu_ram_aw}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_writes", wr_cnt - wr0, 20);
        check("abort_nodone", done_cnt - dn0, 0);

        fill_uniform(-3, 200);
        run_block("post_abort", 1'b0, 1'b0);
        check("post_abort_data", const_errs(15'h7FFF), 0);

        // Random blocks with shuffled index table against the reference.
        for (int b = 0; b < 4; b++) begin
            logic c;
            for (int i = 0; i < 64; i++) begin
                zz_mem[i]  = 6'(zz_std[i]);
                dct_mem[i] = 18'($urandom);
            end
            for (int i = 63; i > 0; i--) begin
                int         j;
                logic [5:0] t;
                j = int'($urandom_range(i, 0));
                t = zz_mem[i];
                zz_mem[i] = zz_mem[j];
                zz_mem[j] = t;
            end
            for (int i = 0; i < 128; i++) fd_mem[i] = 8'($urandom);
            c = 1'($urandom);
            run_block($sformatf("rand%0d", b), c, 1'b0);
            check($sformatf("rand%0d_model", b), model_errs(c), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
